// File: rtl/shift_reg_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_unit
//  Description : Parametrised operand/result register with parallel load,
//                clear, shift, rotate and a multi-cycle shift-by-N sequencer
//                that reports its progress through a busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_reg_unit #(
  parameter int WIDTH     = 8,
  parameter int SHAMT_W   = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   d,
  input  logic               ser_in,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qn,
  output logic               cout,
  output logic               busy,
  output logic               done
);

  // Operating mode encodings
  localparam logic [2:0] C_MODE_HOLD = 3'b000;
  localparam logic [2:0] C_MODE_LOAD = 3'b001;
  localparam logic [2:0] C_MODE_SHL  = 3'b010;
  localparam logic [2:0] C_MODE_SHR  = 3'b011;
  localparam logic [2:0] C_MODE_ROL  = 3'b100;
  localparam logic [2:0] C_MODE_ROR  = 3'b101;
  localparam logic [2:0] C_MODE_ASR  = 3'b110;
  localparam logic [2:0] C_MODE_CLR  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic               cout_q,  cout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [2:0]         op_q,    op_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;

  logic [WIDTH-1:0]   w_step_data;
  logic               w_step_cout;
  logic [2:0]         w_step_mode;
  logic               w_seq_mode;

  // Only the shift/rotate modes can be sequenced; HOLD/LOAD/CLR with start
  // behave as ordinary single-cycle commands.
  assign w_seq_mode = (mode >= C_MODE_SHL) && (mode <= C_MODE_ASR);

  // While running, the latched operation drives the step logic, not mode.
  assign w_step_mode = (state_q == RUN) ? op_q : mode;

  // One step of the selected operation applied to the current contents.
  always_comb begin
    w_step_data = data_q;
    w_step_cout = cout_q;
    case (w_step_mode)
      C_MODE_HOLD: begin
        w_step_data = data_q;
        w_step_cout = cout_q;
      end
      C_MODE_LOAD: begin
        w_step_data = d;
        w_step_cout = 1'b0;
      end
      C_MODE_SHL: begin
        w_step_data = {data_q[WIDTH-2:0], ser_in};
        w_step_cout = data_q[WIDTH-1];
      end
      C_MODE_SHR: begin
        w_step_data = {ser_in, data_q[WIDTH-1:1]};
        w_step_cout = data_q[0];
      end
      C_MODE_ROL: begin
        w_step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        w_step_cout = data_q[WIDTH-1];
      end
      C_MODE_ROR: begin
        w_step_data = {data_q[0], data_q[WIDTH-1:1]};
        w_step_cout = data_q[0];
      end
      C_MODE_ASR: begin
        w_step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        w_step_cout = data_q[0];
      end
      C_MODE_CLR: begin
        w_step_data = '0;
        w_step_cout = 1'b0;
      end
      default: begin
        w_step_data = data_q;
        w_step_cout = cout_q;
      end
    endcase
  end

  // Next-state logic for the register and the shift-by-N sequencer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    op_d    = op_q;
    cnt_d   = cnt_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start && w_seq_mode) begin
            // Acceptance edge: latch the command, do not step yet.
            op_d  = mode;
            cnt_d = shamt;
            if (shamt == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              busy_d  = 1'b1;
            end
          end else begin
            data_d = w_step_data;
            cout_d = w_step_cout;
          end
        end
        RUN: begin
          data_d = w_step_data;
          cout_d = w_step_cout;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= RESET_VAL;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= C_MODE_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q    = data_q;
  assign qn   = ~data_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
